// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter with split-read tracking and a grant watchdog.
// Define SPLIT_ARB_ROUND_ROBIN_EN for alternating arbitration; default is fixed priority to master 0.
module split_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] m_req,
    output logic [1:0] m_grant,
    input  logic       target_ack,
    input  logic       target_split_ack,
    input  logic       split_req,
    output logic       split_grant,
    output logic       split_pending,
    output logic       split_owner,
    output logic       timeout,
    output logic       split_err
);

    // A zero TIMEOUT_CYCLES disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        SPLIT_RET = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      m_grant_q, m_grant_d;
    logic            split_grant_q, split_grant_d;
    logic            split_pending_q, split_pending_d;
    logic            split_owner_q, split_owner_d;
    logic            timeout_q, timeout_d;
    logic            split_err_q, split_err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [1:0]      eligible;
    logic            winner;
    logic            granted_idx;
    logic            wd_expire;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
    logic            last_grant_q, last_grant_d;
`endif

    always_comb begin
        eligible    = m_req & ~({2{split_pending_q}} & (split_owner_q ? 2'b10 : 2'b01));
        granted_idx = m_grant_q[1];
        wd_expire   = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
        winner = (&eligible) ? ~last_grant_q : eligible[1];
`else
        winner = ~eligible[0];
`endif
    end

    always_comb begin
        state_d         = state_q;
        m_grant_d       = m_grant_q;
        split_grant_d   = 1'b0;
        timeout_d       = 1'b0;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        split_err_d     = split_err_q;
        wd_d            = wd_q;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
        last_grant_d    = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (split_req && split_pending_q) begin
                    state_d       = SPLIT_RET;
                    split_grant_d = 1'b1;
                    m_grant_d     = split_owner_q ? 2'b10 : 2'b01;
                    wd_d          = '0;
                end else if (|eligible) begin
                    state_d   = GRANT;
                    m_grant_d = winner ? 2'b10 : 2'b01;
                    wd_d      = '0;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
                    last_grant_d = winner;
`endif
                end
            end
            GRANT: begin
                wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
                // Split ack outranks a simultaneous plain ack; an overlapping split keeps its owner.
                if (target_split_ack) begin
                    state_d   = IDLE;
                    m_grant_d = '0;
                    if (split_pending_q) begin
                        split_err_d = 1'b1;
                    end else begin
                        split_pending_d = 1'b1;
                        split_owner_d   = granted_idx;
                    end
                end else if (target_ack || !m_req[granted_idx]) begin
                    state_d   = IDLE;
                    m_grant_d = '0;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    m_grant_d = '0;
                    timeout_d = 1'b1;
                end
            end
            SPLIT_RET: begin
                wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
                if (target_ack || wd_expire) begin
                    state_d         = IDLE;
                    m_grant_d       = '0;
                    split_pending_d = 1'b0;
                    timeout_d       = !target_ack;
                end
            end
            default: begin
                state_d   = IDLE;
                m_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            m_grant_q       <= '0;
            split_grant_q   <= 1'b0;
            split_pending_q <= 1'b0;
            split_owner_q   <= 1'b0;
            timeout_q       <= 1'b0;
            split_err_q     <= 1'b0;
            wd_q            <= '0;
        end else begin
            state_q         <= state_d;
            m_grant_q       <= m_grant_d;
            split_grant_q   <= split_grant_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            timeout_q       <= timeout_d;
            split_err_q     <= split_err_d;
            wd_q            <= wd_d;
        end
    end

`ifdef SPLIT_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign m_grant       = m_grant_q;
    assign split_grant   = split_grant_q;
    assign split_pending = split_pending_q;
    assign split_owner   = split_owner_q;
    assign timeout       = timeout_q;
    assign split_err     = split_err_q;

endmodule

// File: doc/split_bus_arbiter.md
# split_bus_arbiter

Two-master bus arbiter with split-transaction support for the serial bus. It grants the shared bus to one master at a time and records which master owns a read that the target has split. When the split target later raises `split_req`, the arbiter re-grants the bus to that master for the data return. It sits between the master ports and the address/data mux, beside the split-capable target.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles a grant may be held without `target_ack`/`target_split_ack`; 0 disables the watchdog.
- `clk` in 1: bus clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_req` in 2: per-master request; bit i belongs to master i.
- `m_grant` out 2: one-hot or zero grant, registered.
- `target_ack` in 1: one-cycle pulse; the transaction completed.
- `target_split_ack` in 1: one-cycle pulse; the target deferred a read.
- `split_req` in 1: level from the split target; ready to return read data.
- `split_grant` out 1: one-cycle pulse acknowledging `split_req`.
- `split_pending` out 1: a split read is outstanding.
- `split_owner` out 1: index of the master that owns the outstanding split.
- `timeout` out 1: one-cycle pulse when the watchdog fires.
- `split_err` out 1: sticky; set when `target_split_ack` arrives while `split_pending` is already 1.

## Operation
- States: IDLE, GRANT, SPLIT_RET.
- Eligible master i: `m_req[i]`=1, and not (`split_pending` and `split_owner`==i). The split owner is masked until its data returns.
- IDLE:
  - If `split_req`=1 and `split_pending`=1: go to SPLIT_RET, pulse `split_grant`, set `m_grant[split_owner]`. This has priority over new requests.
  - Else if any master is eligible: select a winner, set its `m_grant` bit, clear the watchdog, go to GRANT.
  - A `split_req` that arrives while `split_pending`=0 is ignored.
- GRANT, ending on any of the following, all returning to IDLE:
  - `target_ack`: clear the grant.
  - `target_split_ack`: clear the grant and set `split_pending`=1 with `split_owner`=granted index. If `split_pending` was already 1, set `split_err` and leave the existing owner unchanged.
  - Granted master drops `m_req` (abort): clear the grant.
  - Watchdog reaches `TIMEOUT_CYCLES`-1: clear the grant and pulse `timeout`.
- SPLIT_RET:
  - Hold `m_grant[split_owner]`.
  - On `target_ack`: clear the grant and `split_pending`, go to IDLE.
  - `m_req` is not checked.
  - On watchdog expiry: clear the grant and `split_pending`, pulse `timeout`, go to IDLE.
- When `target_ack` and `target_split_ack` arrive in the same cycle, `target_split_ack` wins.
- Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates rather than wrapping.
- `last_grant` register (1 bit) records the most recent GRANT winner; it is not updated in SPLIT_RET.

## Timing
- Reset values: `m_grant`=0, `split_grant`=0, `split_pending`=0, `split_owner`=0, `timeout`=0, `split_err`=0, state=IDLE, `last_grant`=1, watchdog=0.
- A request sampled in IDLE at edge N produces its grant visible after edge N (1-cycle latency).
- A completion sampled at edge N drops the grant after edge N.
- At least one IDLE cycle (bus turnaround) separates consecutive grants.
- `split_grant` is high for exactly one cycle. The target deasserts `split_req` after seeing it, then returns data and `target_ack` 2 cycles later.
- The watchdog increments every cycle in GRANT and SPLIT_RET.
- Reset asserted mid-transaction clears all state immediately, including an outstanding split. No completion is reported.

## Configuration
- Macro: `SPLIT_ARB_ROUND_ROBIN_EN`.
- Defined: when both masters are eligible, the master not equal to `last_grant` wins (alternation).
- Undefined: fixed priority; master 0 always wins when both are eligible, and `last_grant` is unused.
- With only one master eligible, both builds behave identically.

## Test plan
- Single write: `m_req`=01, `target_ack` 3 cycles after the grant -> `m_grant`=01 for exactly 3 cycles, then 00 for at least 1 cycle; no flags set.
- Split read: master 1 granted, `target_split_ack` pulses -> `split_pending`=1, `split_owner`=1. `split_req` 4 cycles later -> `split_grant` one pulse, `m_grant`=10 until `target_ack`, then `split_pending`=0.
- Owner masking: while master 1's split is pending, `m_req`=11 -> only master 0 is granted. `split_req` during master 0's grant is served in the first IDLE after master 0 completes.
- Contention, `m_req`=11 held, each transaction acked after 2 cycles:
  - With the macro defined: grant sequence 01, 10, 01, 10.
  - Without the macro: 01, 01, 01.
- Watchdog, `TIMEOUT_CYCLES`=8, no ack: `m_grant` drops after 8 cycles, `timeout` pulses once, state returns to IDLE. A second `target_split_ack` while a split is pending -> `split_err`=1 and it stays set until reset.
- Reset in SPLIT_RET: assert `rst_n`=0 mid-return -> all outputs go to their reset values asynchronously; `split_pending`=0 after release.
